// File: rtl/imem_controller.sv
// Instruction memory sequencer: boot loader writes the byte image, then the CPU
// fetches 32-bit little-endian words with a registered, range-checked response.
module imem_controller #(
  parameter int ADDR_WIDTH = 10,
  parameter bit BOOT_HOLD  = 1'b1
) (
  input  logic                  I_clk,
  input  logic                  I_rst_n,
  input  logic                  I_fetch_req,
  input  logic [31:0]           I_fetch_addr,
  output logic                  O_fetch_ready,
  output logic                  O_fetch_valid,
  output logic [31:0]           O_fetch_data,
  output logic                  O_fetch_fault,
  input  logic                  I_load_valid,
  input  logic [7:0]            I_load_data,
  output logic                  O_load_ready,
  input  logic                  I_load_done,
  input  logic                  I_load_restart,
  output logic [ADDR_WIDTH:0]   O_load_count,
  output logic                  O_load_overflow,
  output logic                  O_cpu_hold,
  output logic [ADDR_WIDTH-1:0] O_mem_addr,
  output logic [7:0]            O_mem_wdata,
  output logic                  O_mem_we,
  input  logic [31:0]           I_mem_rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL      = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [31:0]         LAST_WORD = 32'(DEPTH - 4);
  localparam logic [31:0]         NOP       = 32'h0000_0013;

  typedef enum logic {BOOT, RUN} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            wdata_q;
  logic                  fetch_hs, fault;

  always_comb begin
    state_d       = state_q;
    O_cpu_hold    = 1'b0;
    O_fetch_ready = 1'b0;
    O_load_ready  = 1'b0;
    O_mem_we      = 1'b0;
    case (state_q)
      BOOT: begin
        O_cpu_hold   = 1'b1;
        O_load_ready = (O_load_count != FULL);
        O_mem_we     = O_load_ready & I_load_valid;
        if (I_load_restart)   state_d = BOOT;
        else if (I_load_done) state_d = RUN;
      end
      default: begin
        O_fetch_ready = 1'b1;
        if (I_load_restart) state_d = BOOT;
      end
    endcase
  end

  assign fetch_hs = O_fetch_ready & I_fetch_req;
  // Address bits above the array also fail the range compare.
  assign fault    = (|I_fetch_addr[1:0]) | (I_fetch_addr > LAST_WORD);

  // Memory port holds its last driven address/data when idle; O_mem_we qualifies it.
  assign O_mem_addr  = O_mem_we ? O_load_count[ADDR_WIDTH-1:0] :
                       fetch_hs ? I_fetch_addr[ADDR_WIDTH-1:0] : addr_q;
  assign O_mem_wdata = O_mem_we ? I_load_data : wdata_q;

  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      state_q         <= BOOT_HOLD ? BOOT : RUN;
      O_load_count    <= '0;
      O_load_overflow <= 1'b0;
      O_fetch_valid   <= 1'b0;
      O_fetch_data    <= '0;
      O_fetch_fault   <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= O_mem_addr;
      wdata_q       <= O_mem_wdata;
      O_fetch_valid <= fetch_hs & ~I_load_restart;
      if (fetch_hs && !I_load_restart) begin
        O_fetch_fault <= fault;
        O_fetch_data  <= fault ? NOP : I_mem_rdata;
      end
      if (I_load_restart) begin
        O_load_count    <= '0;
        O_load_overflow <= 1'b0;
      end else if (state_q == BOOT) begin
        if (O_mem_we) O_load_count <= O_load_count + 1'b1;
        if (O_load_count == FULL && I_load_valid) O_load_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_controller.sv
// Randomised bench for imem_controller with a byte-image reference model and
// a behavioural memory array attached to the memory port.
module tb_imem_controller;
  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic I_clk = 1'b0, I_rst_n = 1'b0;
  logic I_fetch_req = 0, O_fetch_ready, O_fetch_valid, O_fetch_fault;
  logic [31:0] I_fetch_addr = '0, O_fetch_data, I_mem_rdata;
  logic I_load_valid = 0, O_load_ready, I_load_done = 0, I_load_restart = 0;
  logic [7:0] I_load_data = '0, O_mem_wdata;
  logic [AW:0] O_load_count;
  logic O_load_overflow, O_cpu_hold, O_mem_we;
  logic [AW-1:0] O_mem_addr;

  imem_controller #(.ADDR_WIDTH(AW), .BOOT_HOLD(1'b1)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_fetch_req(I_fetch_req), .I_fetch_addr(I_fetch_addr),
    .O_fetch_ready(O_fetch_ready), .O_fetch_valid(O_fetch_valid),
    .O_fetch_data(O_fetch_data), .O_fetch_fault(O_fetch_fault),
    .I_load_valid(I_load_valid), .I_load_data(I_load_data), .O_load_ready(O_load_ready),
    .I_load_done(I_load_done), .I_load_restart(I_load_restart),
    .O_load_count(O_load_count), .O_load_overflow(O_load_overflow), .O_cpu_hold(O_cpu_hold),
    .O_mem_addr(O_mem_addr), .O_mem_wdata(O_mem_wdata), .O_mem_we(O_mem_we),
    .I_mem_rdata(I_mem_rdata));

  always #5 I_clk = ~I_clk;

  // Physical memory, written only through the DUT's port.
  logic [7:0] mem [0:DEPTH-1];
  // Model's view of what the image should contain.
  logic [7:0] img [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) begin mem[i] = 8'h00; img[i] = 8'h00; end

  always @(posedge I_clk) if (O_mem_we) mem[O_mem_addr] <= O_mem_wdata;
  assign I_mem_rdata = {mem[O_mem_addr + 10'd3], mem[O_mem_addr + 10'd2],
                        mem[O_mem_addr + 10'd1], mem[O_mem_addr]};

  int checks = 0, fails = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state after each edge.
  bit         mdl_on = 0, m_boot, m_ovf, m_vld, m_fault;
  int         m_cnt;
  logic [31:0] m_data;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wdata;

  function automatic logic [31:0] word_at(input int a);
    return {img[a+3], img[a+2], img[a+1], img[a]};
  endfunction

  always @(posedge I_clk) begin
    if (!I_rst_n) begin
      mdl_on = 1; m_boot = 1; m_cnt = 0; m_ovf = 0; m_vld = 0;
      m_data = 0; m_fault = 0; m_addr = 0; m_wdata = 0;
    end else if (m_boot) begin
      m_vld = 0;
      if (m_cnt < DEPTH && I_load_valid) begin
        img[m_cnt] = I_load_data; m_addr = AW'(m_cnt); m_wdata = I_load_data; m_cnt++;
      end else if (m_cnt == DEPTH && I_load_valid) m_ovf = 1;
      if (I_load_restart) begin m_cnt = 0; m_ovf = 0; end
      else if (I_load_done) m_boot = 0;
    end else begin
      if (I_fetch_req) m_addr = I_fetch_addr[AW-1:0];
      if (I_load_restart) begin m_boot = 1; m_cnt = 0; m_ovf = 0; m_vld = 0; end
      else if (I_fetch_req) begin
        m_vld = 1;
        m_fault = (I_fetch_addr % 4 != 0) || (longint'(I_fetch_addr) > DEPTH - 4);
        m_data = m_fault ? 32'h13 : word_at(int'(I_fetch_addr));
      end else m_vld = 0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge I_clk) if (mdl_on && I_rst_n) begin
    bit e_lr, e_we, e_fhs;
    logic [AW-1:0] e_addr;
    e_lr  = m_boot && m_cnt < DEPTH;
    e_we  = e_lr && I_load_valid;
    e_fhs = !m_boot && I_fetch_req;
    e_addr = e_we ? AW'(m_cnt) : e_fhs ? I_fetch_addr[AW-1:0] : m_addr;
    check("cpu_hold", 32'(O_cpu_hold), 32'(m_boot));
    check("fetch_ready", 32'(O_fetch_ready), 32'(!m_boot));
    check("load_ready", 32'(O_load_ready), 32'(e_lr));
    check("mem_we", 32'(O_mem_we), 32'(e_we));
    check("mem_addr", 32'(O_mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(O_mem_wdata), 32'(e_we ? I_load_data : m_wdata));
    check("load_count", 32'(O_load_count), 32'(m_cnt));
    check("overflow", 32'(O_load_overflow), 32'(m_ovf));
    check("fetch_valid", 32'(O_fetch_valid), 32'(m_vld));
    check("fetch_data", O_fetch_data, m_data);
    check("fetch_fault", 32'(O_fetch_fault), 32'(m_fault));
  end

  task automatic step(); @(posedge I_clk); #1; endtask
  task automatic idle();
    I_fetch_req = 0; I_load_valid = 0; I_load_done = 0; I_load_restart = 0;
  endtask

  initial begin
    logic [7:0] boot_bytes [4];
    boot_bytes = '{8'h13, 8'h05, 8'h50, 8'h00};
    repeat (3) step();
    check("rst_hold", 32'(O_cpu_hold), 32'd1);
    check("rst_count", 32'(O_load_count), 32'd0);
    check("rst_valid", 32'(O_fetch_valid), 32'd0);
    I_rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      I_load_valid = 1; I_load_data = boot_bytes[i]; step();
    end
    idle();
    check("boot_count4", 32'(O_load_count), 32'd4);
    check("boot_fready", 32'(O_fetch_ready), 32'd0);
    I_load_done = 1; step(); idle();
    check("run_hold", 32'(O_cpu_hold), 32'd0);
    // Back-to-back fetches; the first also pins the assembled little-endian word.
    I_fetch_req = 1; I_fetch_addr = 0; step();
    check("w0_valid", 32'(O_fetch_valid), 32'd1);
    check("w0_data", O_fetch_data, 32'h0050_0513);
    check("w0_fault", 32'(O_fetch_fault), 32'd0);
    I_fetch_addr = 4; step();
    check("w4_valid", 32'(O_fetch_valid), 32'd1);
    check("w4_data", O_fetch_data, 32'h0);
    I_fetch_addr = 8; step();
    check("w8_valid", 32'(O_fetch_valid), 32'd1);
    I_fetch_addr = 2; step();
    check("f2_fault", 32'(O_fetch_fault), 32'd1);
    check("f2_data", O_fetch_data, 32'h13);
    I_fetch_addr = 32'h400; step();
    check("f400_fault", 32'(O_fetch_fault), 32'd1);
    check("f400_data", O_fetch_data, 32'h13);
    I_fetch_addr = 32'd1020; step(); idle();
    check("f1020_fault", 32'(O_fetch_fault), 32'd0);
    step();
    check("valid_drop", 32'(O_fetch_valid), 32'd0);

    // Random mix of loading, done, restart, fetches and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      I_rst_n = ($urandom_range(0, 499) != 0);
      I_load_valid = $urandom_range(0, 1);
      I_load_data = 8'($urandom);
      I_load_done = ($urandom_range(0, 29) == 0);
      I_load_restart = ($urandom_range(0, 79) == 0) && !I_load_valid;
      I_fetch_req = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: I_fetch_addr = $urandom;
        1: I_fetch_addr = 32'($urandom_range(0, 1023));
        default: I_fetch_addr = 32'($urandom_range(0, 63)) << 2;
      endcase
      step();
    end
    idle(); I_rst_n = 1;

    // Fill the whole array, then offer one more byte.
    I_load_restart = 1; step(); idle();
    for (int i = 0; i < DEPTH; i++) begin
      I_load_valid = 1; I_load_data = 8'($urandom); step();
    end
    check("full_count", 32'(O_load_count), 32'd1024);
    @(negedge I_clk);
    check("full_lready", 32'(O_load_ready), 32'd0);
    check("full_we", 32'(O_mem_we), 32'd0);
    step(); idle();
    check("ovf_set", 32'(O_load_overflow), 32'd1);
    repeat (3) step();
    check("ovf_sticky", 32'(O_load_overflow), 32'd1);
    I_load_done = 1; step(); idle();
    for (int i = 0; i < 300; i++) begin
      I_fetch_req = $urandom_range(0, 3) != 0;
      I_fetch_addr = 32'($urandom_range(0, 255)) << 2;
      step();
    end
    idle(); step();
    check("ovf_run", 32'(O_load_overflow), 32'd1);

    // Fetch and restart together: restart wins, no response.
    I_fetch_req = 1; I_fetch_addr = 0; I_load_restart = 1; step(); idle();
    check("rs_valid", 32'(O_fetch_valid), 32'd0);
    check("rs_hold", 32'(O_cpu_hold), 32'd1);
    check("rs_count", 32'(O_load_count), 32'd0);
    check("rs_ovf", 32'(O_load_overflow), 32'd0);
    for (int i = 0; i < 5; i++) begin I_load_valid = 1; I_load_data = 8'(i); step(); end
    idle();
    check("mid_count", 32'(O_load_count), 32'd5);
    I_rst_n = 0; step(); I_rst_n = 1;
    check("mid_rst_count", 32'(O_load_count), 32'd0);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/imem_controller.md
Name: imem_controller

Overview:
- Sequences all access to the byte-addressed instruction memory: a boot loader writes the image one byte at a time, then the CPU fetch port reads 32-bit little-endian words.
- Holds the CPU while the image loads and arbitrates between loader and fetch.
- Registers fetch responses (1-cycle latency) and range/alignment-checks every fetch.
- Sits between the core's fetch stage, the boot-loader byte stream and the instruction memory array.

Parameters:
- ADDR_WIDTH, 10, byte-address width of the memory (depth 2^ADDR_WIDTH bytes).
- BOOT_HOLD, 1, 1 = leave reset in BOOT (CPU held until load done); 0 = leave reset directly in RUN.

Ports:
- I_clk  input  1  clock, rising edge.
- I_rst_n  input  1  synchronous active-low reset.
- I_fetch_req  input  1  CPU fetch request.
- I_fetch_addr  input  32  CPU fetch byte address.
- O_fetch_ready  output  1  fetch accepted this cycle when high with I_fetch_req.
- O_fetch_valid  output  1  response valid, one cycle.
- O_fetch_data  output  32  fetched word.
- O_fetch_fault  output  1  response is a fault (misaligned or out of range).
- I_load_valid  input  1  loader byte available.
- I_load_data  input  8  loader byte.
- O_load_ready  output  1  loader byte accepted when high with I_load_valid.
- I_load_done  input  1  loader finished; release CPU.
- I_load_restart  input  1  rewind loader and re-enter BOOT.
- O_load_count  output  ADDR_WIDTH+1  bytes written since last rewind.
- O_load_overflow  output  1  sticky: byte offered with memory full.
- O_cpu_hold  output  1  CPU must stay stalled/reset.
- O_mem_addr  output  ADDR_WIDTH  memory byte address.
- O_mem_wdata  output  8  memory write byte.
- O_mem_we  output  1  memory byte write enable.
- I_mem_rdata  input  32  combinational read of bytes addr+3..addr, little-endian.

Behaviour:

Reset (I_rst_n low at a clock edge):
- State is BOOT if BOOT_HOLD=1, else RUN.
- Load pointer is 0.
- O_load_count=0, O_load_overflow=0, O_fetch_valid=0, O_fetch_data=0, O_fetch_fault=0.
- O_mem_we=0, O_mem_addr=0, O_mem_wdata=0.
- O_cpu_hold = (BOOT_HOLD=1).
- Reset mid-operation discards any pending response and any partial load.

State BOOT:
- O_cpu_hold=1, O_fetch_ready=0.
- O_load_ready=1 while O_load_count < 2^ADDR_WIDTH.
- On load handshake, combinationally in the same cycle: O_mem_we=1, O_mem_addr=pointer, O_mem_wdata=I_load_data.
- Also on load handshake, registered: pointer and O_load_count each increment by 1.
- Full condition (O_load_count = 2^ADDR_WIDTH): O_load_ready=0, and I_load_valid=1 sets O_load_overflow. No write, no wrap-around.
- I_load_done=1 → RUN next cycle. A byte handshaken in the same cycle is still written.
- I_load_restart has priority over I_load_done. It clears pointer, O_load_count and O_load_overflow, and the state stays BOOT.

State RUN:
- O_cpu_hold=0, O_load_ready=0, O_mem_we=0.
- Loader bytes are ignored and do not set overflow.
- O_fetch_ready=1 every cycle, so back-to-back fetches are allowed and there is no stall.
- On fetch handshake, combinationally: O_mem_addr = I_fetch_addr[ADDR_WIDTH-1:0].
- On the next edge, O_fetch_valid=1 for exactly one cycle.
- O_fetch_valid=0 in any cycle following one with no handshake. O_fetch_data and O_fetch_fault hold their last values while valid is low.
- Fault if I_fetch_addr[1:0] != 0, or I_fetch_addr > 2^ADDR_WIDTH-4, or any bit of I_fetch_addr above ADDR_WIDTH-1 is set.
- On fault: O_fetch_fault=1, O_fetch_data=0x00000013 (NOP).
- Otherwise: O_fetch_fault=0, O_fetch_data = I_mem_rdata.
- I_load_restart=1 → BOOT next cycle. Pointer, count and overflow are cleared, O_cpu_hold rises the next cycle, and any response due next cycle is suppressed (O_fetch_valid=0).
- If a fetch and a restart occur together, the restart wins and no response is issued.
- I_load_done is ignored in RUN.
- When idle, O_mem_addr holds the last driven value. Only O_mem_we qualifies the memory port.

Test Plan:
- Reset with BOOT_HOLD=1, then stream bytes 0x13,0x05,0x50,0x00 at one per cycle with I_load_valid held → four writes at addresses 0..3, O_load_count=4, O_cpu_hold=1, O_fetch_ready=0.
- Pulse I_load_done, then fetch address 0 → O_cpu_hold=0 next cycle; one cycle after the fetch handshake, O_fetch_valid=1, O_fetch_data=0x00500513, O_fetch_fault=0.
- Back-to-back fetches of addresses 0, 4 and 8 → three consecutive valid cycles in order; valid drops the cycle after the last one.
- Fetch addresses 0x2 and 0x400 (ADDR_WIDTH=10) → O_fetch_fault=1 and data 0x00000013 for both, and no memory write occurs.
- Load 1024 bytes, then offer a 1025th byte → O_load_ready=0 and no write at count 1024; O_load_overflow=1 stays set until restart.
- In RUN, assert a fetch and I_load_restart in the same cycle → no O_fetch_valid follows, state is BOOT, O_load_count=0, O_cpu_hold=1; a subsequent reset mid-load clears the count to 0.
